// File: rtl/mix_columns_seq.sv
// mix_columns_seq: multi-cycle AES MixColumns engine over a 128-bit state.
// PAR_COLS (1, 2 or 4) columns are transformed per cycle; a state takes
// 4/PAR_COLS cycles. Valid/ready handshake on both input and output.
// Optional build macro INV_MIX_COLUMNS_EN adds InvMixColumns selected by inv_in;
// without it inv_in is ignored and only the forward transform is built.
module mix_columns_seq #(
  parameter int PAR_COLS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] state_in,
  input  logic         inv_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] state_o,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy_o
);

  localparam int NCYC = 4 / PAR_COLS;

  generate
    if (PAR_COLS != 1 && PAR_COLS != 2 && PAR_COLS != 4) begin : g_bad_par_cols
      $error("mix_columns_seq: PAR_COLS must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_col_cnt;
  logic [127:0] r_data;
  logic [127:0] w_data_nxt;
  logic         w_last;

  // GF(2^8) multiply by 2 with the AES reduction polynomial
  function automatic logic [7:0] f_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns on one column, row 0 in the low byte
  function automatic logic [31:0] f_mix_fwd(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] t;
    logic [31:0] b;
    for (int unsigned r = 0; r < 4; r++) begin
      a[r] = col[8*r +: 8];
    end
    t = a[0] ^ a[1] ^ a[2] ^ a[3];
    b = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      b[8*r +: 8] = a[r] ^ t ^ f_xtime(a[r] ^ a[(r + 1) % 4]);
    end
    return b;
  endfunction

`ifdef INV_MIX_COLUMNS_EN
  logic r_inv;

  // Inverse = preprocessing step followed by the forward transform,
  // so both modes share the forward datapath.
  function automatic logic [31:0] f_inv_pre(input logic [31:0] col);
    logic [7:0] u;
    logic [7:0] v;
    u = f_xtime(f_xtime(col[7:0] ^ col[23:16]));
    v = f_xtime(f_xtime(col[15:8] ^ col[31:24]));
    return col ^ {v, u, v, u};
  endfunction

  function automatic logic [31:0] f_col(input logic [31:0] col, input logic inv);
    return f_mix_fwd(inv ? f_inv_pre(col) : col);
  endfunction
`else
  logic w_unused_inv;
  assign w_unused_inv = inv_in;

  function automatic logic [31:0] f_col(input logic [31:0] col);
    return f_mix_fwd(col);
  endfunction
`endif

  assign w_last    = (r_col_cnt == 2'(PAR_COLS * (NCYC - 1)));
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy_o    = (r_state != S_IDLE);
  assign state_o   = r_data;

  // Shared column datapath: transform the PAR_COLS columns at r_col_cnt
  always_comb begin
    logic [1:0]  idx;
    logic [31:0] col;
    w_data_nxt = r_data;
    idx        = '0;
    col        = '0;
    for (int unsigned p = 0; p < PAR_COLS; p++) begin
      idx = r_col_cnt + 2'(p);
      col = r_data[32*idx +: 32];
`ifdef INV_MIX_COLUMNS_EN
      w_data_nxt[32*idx +: 32] = f_col(col, r_inv);
`else
      w_data_nxt[32*idx +: 32] = f_col(col);
`endif
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Data register, column counter and mode flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_col_cnt <= '0;
`ifdef INV_MIX_COLUMNS_EN
      r_inv     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data    <= state_in;
            r_col_cnt <= '0;
`ifdef INV_MIX_COLUMNS_EN
            r_inv     <= inv_in;
`endif
          end
        end
        S_BUSY: begin
          r_data    <= w_data_nxt;
          r_col_cnt <= w_last ? 2'd0 : r_col_cnt + 2'(PAR_COLS);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: three instances (PAR_COLS 1, 2, 4)
// checked against a GF(2^8) matrix-multiply reference model.
module tb_mix_columns_seq;

`ifdef INV_MIX_COLUMNS_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] state_in  [3];
  logic         inv_in    [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] state_o   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         busy_o    [3];

  int compares = 0;
  int fails    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_seq #(.PAR_COLS(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .state_in  (state_in[g]),
      .inv_in    (inv_in[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .state_o   (state_o[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .busy_o    (busy_o[g])
    );
  end

  // Generic GF(2^8) multiply, polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] aa;
    logic [7:0] p;
    aa = {1'b0, a};
    p  = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h11b;
    end
    return p;
  endfunction

  // Reference: circulant matrix multiply per column
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0]   cf [4];
    logic [7:0]   a  [4];
    logic [7:0]   b;
    logic [127:0] res;
    if (inv) begin
      cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9;
    end else begin
      cf[0] = 8'd2;  cf[1] = 8'd3;  cf[2] = 8'd1;  cf[3] = 8'd1;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[32*c + 8*r +: 8];
      for (int r = 0; r < 4; r++) begin
        b = '0;
        for (int k = 0; k < 4; k++) b = b ^ gmul(cf[k], a[(r + k) % 4]);
        res[32*c + 8*r +: 8] = b;
      end
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one job on instance k and wait for out_valid (bounded)
  task automatic run_job(input int k, input logic [127:0] d, input bit inv, input int ncyc,
                         input string tag);
    int lat;
    logic [127:0] exp;
    exp = ref_mix(d, inv && INV_EN);
    chk({tag, "_in_ready"}, 128'(in_ready[k]), 128'd1);
    state_in[k] = d;
    inv_in[k]   = inv;
    in_valid[k] = 1'b1;
    out_ready[k] = 1'b0;
    step();
    in_valid[k] = 1'b0;
    state_in[k] = '0;
    chk({tag, "_busy"}, 128'(busy_o[k]), 128'd1);
    lat = 0;
    while (!out_valid[k] && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(ncyc));
    chk({tag, "_result"}, state_o[k], exp);
  endtask

  // Complete the output handshake and confirm return to IDLE
  task automatic finish_job(input int k, input string tag);
    out_ready[k] = 1'b1;
    step();
    out_ready[k] = 1'b0;
    chk({tag, "_idle_ready"}, 128'(in_ready[k]), 128'd1);
    chk({tag, "_idle_valid"}, 128'(out_valid[k]), 128'd0);
  endtask

  localparam logic [127:0] T1_IN  = 128'h4c31262d_01010101_5c220af2_455313db;
  localparam logic [127:0] T1_OUT = 128'hf8bd7e4d_01010101_9d58dc9f_bca14d8e;
  localparam logic [127:0] T3_IN  = 128'hd5d4d4d4_c6c6c6c6_01010101_455313db;
  localparam logic [127:0] T3_OUT = 128'hd6d7d5d5_c6c6c6c6_01010101_bca14d8e;

  initial begin
    logic [127:0] held;
    logic [127:0] exp_q [$];
    logic [127:0] d;
    bit           acc, done;
    int           last_acc, naccept, nres;

    for (int k = 0; k < 3; k++) begin
      state_in[k] = '0; inv_in[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
    end
    #12;
    // Reset state, also with in_valid asserted (must be ignored)
    in_valid[0] = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", 128'(out_valid[k]), 128'd0);
      chk("rst_state_o", state_o[k], '0);
      chk("rst_busy", 128'(busy_o[k]), 128'd0);
    end
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) chk("post_rst_in_ready", 128'(in_ready[k]), 128'd1);

    // Known forward vector, PAR_COLS=1
    run_job(0, T1_IN, 1'b0, 4, "t1");
    chk("t1_const", state_o[0], T1_OUT);
    finish_job(0, "t1");
    chk("t1_hold_idle", state_o[0], T1_OUT);

    // Inverse mode (forward when the inverse build option is off)
    run_job(0, T1_OUT, 1'b1, 4, "t2");
    if (INV_EN) chk("t2_const", state_o[0], T1_IN);
    finish_job(0, "t2");

    // PAR_COLS=4 single-cycle processing
    run_job(2, T3_IN, 1'b0, 1, "t3");
    chk("t3_const", state_o[2], T3_OUT);
    finish_job(2, "t3");

    // Backpressure in DONE with in_valid toggling
    d = {$urandom, $urandom, $urandom, $urandom};
    run_job(0, d, 1'b0, 4, "t4");
    held = state_o[0];
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = i[0];
      state_in[0] = {$urandom, $urandom, $urandom, $urandom};
      inv_in[0]   = 1'($urandom);
      step();
      chk("t4_hold_data", state_o[0], held);
      chk("t4_hold_valid", 128'(out_valid[0]), 128'd1);
      chk("t4_in_ready", 128'(in_ready[0]), 128'd0);
    end
    in_valid[0] = 1'b0;
    finish_job(0, "t4");
    chk("t4_no_second_job", 128'(busy_o[0]), 128'd0);
    chk("t4_last_result", state_o[0], held);

    // Reset during second BUSY cycle
    state_in[0] = T1_IN; inv_in[0] = 1'b0; in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 128'(out_valid[0]), 128'd0);
    chk("t5_state_o", state_o[0], '0);
    chk("t5_busy", 128'(busy_o[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_job(0, T1_IN, 1'b0, 4, "t5_rerun");
    chk("t5_rerun_const", state_o[0], T1_OUT);
    finish_job(0, "t5");

    // Random single jobs on every instance
    for (int i = 0; i < 6; i++) begin
      int k;
      k = i % 3;
      d = {$urandom, $urandom, $urandom, $urandom};
      run_job(k, d, 1'($urandom), 4 >> k, "rand");
      finish_job(k, "rand");
    end

    // Back-to-back streaming, PAR_COLS=2
    out_ready[1] = 1'b1;
    in_valid[1]  = 1'b1;
    state_in[1]  = {$urandom, $urandom, $urandom, $urandom};
    inv_in[1]    = 1'($urandom);
    last_acc = -1; naccept = 0; nres = 0;
    for (int cyc = 0; cyc < 80 && nres < 6; cyc++) begin
      acc  = in_valid[1] && in_ready[1];
      done = out_valid[1];
      if (acc) exp_q.push_back(ref_mix(state_in[1], inv_in[1] && INV_EN));
      if (done) begin
        if (exp_q.size() > 0) chk("t6_result", state_o[1], exp_q.pop_front());
        else chk("t6_unexpected_result", 128'(out_valid[1]), 128'd0);
        nres++;
      end
      step();
      if (acc) begin
        naccept++;
        if (last_acc >= 0) chk("t6_accept_interval", 128'(cyc - last_acc), 128'd4);
        last_acc = cyc;
        state_in[1] = {$urandom, $urandom, $urandom, $urandom};
        inv_in[1]   = 1'($urandom);
        if (naccept == 6) in_valid[1] = 1'b0;
      end
    end
    chk("t6_result_count", 128'(nres), 128'd6);
    out_ready[1] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
